// File: rtl/cmn_rr_arb_mux.sv
// Round-robin arbitrated N-to-1 val/rdy mux with a one-entry registered output stage.
// The winning requester's message is buffered and tagged with its source index.
module cmn_rr_arb_mux #(
    parameter  int p_nbits   = 32,
    parameter  int p_ninputs = 4,
    localparam int c_sbits   = $clog2(p_ninputs)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [p_ninputs-1:0]          in_val,
    output logic [p_ninputs-1:0]          in_rdy,
    input  logic [p_ninputs*p_nbits-1:0]  in_msg,
    output logic                          out_val,
    input  logic                          out_rdy,
    output logic [p_nbits-1:0]            out_msg,
    output logic [c_sbits-1:0]            out_src
);

    logic [c_sbits-1:0] ptr;
    logic [c_sbits-1:0] grant_idx;
    logic               grant_val;
    logic [p_nbits-1:0] grant_msg;
    logic [c_sbits-1:0] next_ptr;
    logic               enq_ok;
    logic               in_xfer;
    logic [c_sbits:0]   scan_sum;
    logic [c_sbits-1:0] scan_idx;

    // Scan from ptr upward with wraparound; the first valid requester wins.
    always_comb begin
        grant_val = 1'b0;
        grant_idx = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int off = 0; off < p_ninputs; off++) begin
            scan_sum = {1'b0, ptr} + (c_sbits+1)'(off);
            if (scan_sum >= (c_sbits+1)'(p_ninputs))
                scan_sum = scan_sum - (c_sbits+1)'(p_ninputs);
            scan_idx = scan_sum[c_sbits-1:0];
            if (!grant_val && in_val[scan_idx]) begin
                grant_val = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    always_comb begin
        grant_msg = '0;
        for (int i = 0; i < p_ninputs; i++) begin
            if (grant_idx == c_sbits'(i))
                grant_msg = in_msg[i*p_nbits +: p_nbits];
        end
    end

    assign enq_ok   = !out_val || out_rdy;
    assign in_xfer  = grant_val && enq_ok && !reset;
    assign next_ptr = (grant_idx == c_sbits'(p_ninputs-1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        in_rdy = '0;
        if (in_xfer)
            in_rdy[grant_idx] = 1'b1;
    end

    // The pointer only moves on an accepted input, so stalls keep priority fixed.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_val <= 1'b0;
            out_msg <= '0;
            out_src <= '0;
            ptr     <= '0;
        end else if (in_xfer) begin
            out_val <= 1'b1;
            out_msg <= grant_msg;
            out_src <= grant_idx;
            ptr     <= next_ptr;
        end else if (out_val && out_rdy) begin
            out_val <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cmn_rr_arb_mux.sv
// Self-checking bench for cmn_rr_arb_mux: directed vector table, then random
// traffic compared against a distance-based round-robin reference model.
module tb_cmn_rr_arb_mux;

    localparam int N = 4;
    localparam int W = 32;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   in_val;
    logic [N-1:0]   in_rdy;
    logic [N*W-1:0] in_msg;
    logic           out_val;
    logic           out_rdy;
    logic [W-1:0]   out_msg;
    logic [S-1:0]   out_src;

    always #5 clk = ~clk;

    cmn_rr_arb_mux #(.p_nbits(W), .p_ninputs(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .in_val (in_val),
        .in_rdy (in_rdy),
        .in_msg (in_msg),
        .out_val(out_val),
        .out_rdy(out_rdy),
        .out_msg(out_msg),
        .out_src(out_src)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic         rst;
        logic [N-1:0] val;
        logic [W-1:0] base;
        logic         ordy;
        logic [N-1:0] e_rdy;
        logic         e_oval;
        logic [S-1:0] e_src;
        logic [W-1:0] e_msg;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic [N-1:0] val, logic [W-1:0] base, logic ordy,
                                logic [N-1:0] er, logic eo, logic [S-1:0] es, logic [W-1:0] em);
        vec_t v;
        v.rst = rst; v.val = val; v.base = base; v.ordy = ordy;
        v.e_rdy = er; v.e_oval = eo; v.e_src = es; v.e_msg = em;
        return v;
    endfunction

    // Requester i presents base+i, so the source of any output is visible in its value.
    function automatic logic [N*W-1:0] build_msg(logic [W-1:0] base);
        logic [N*W-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++)
            m[i*W +: W] = base + W'(i);
        return m;
    endfunction

    task automatic compare(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [N-1:0] val,
                                 input logic [N*W-1:0] msg, input logic ordy);
        reset   = rst;
        in_val  = val;
        in_msg  = msg;
        out_rdy = ordy;
    endtask

    task automatic checkOutput(input string tag, input logic [N-1:0] e_rdy, input logic e_oval,
                               input logic [S-1:0] e_src, input logic [W-1:0] e_msg);
        compare({tag, ".in_rdy"},  W'(in_rdy),  W'(e_rdy));
        compare({tag, ".out_val"}, W'(out_val), W'(e_oval));
        compare({tag, ".out_src"}, W'(out_src), W'(e_src));
        compare({tag, ".out_msg"}, out_msg,     e_msg);
    endtask

    // Reference model state: buffered output plus the current highest-priority index.
    logic         m_val;
    logic [W-1:0] m_msg;
    int           m_src;
    int           m_ptr;
    logic [N-1:0] req_v;
    logic [W-1:0] req_m [N];

    // Winner is the valid requester at the smallest rotational distance from m_ptr.
    task automatic modelGrant(input logic [N-1:0] val, output logic found, output int g);
        int best;
        found = 1'b0;
        g     = 0;
        best  = N;
        for (int i = 0; i < N; i++) begin
            if (val[i] && ((i - m_ptr + N) % N) < best) begin
                best  = (i - m_ptr + N) % N;
                g     = i;
                found = 1'b1;
            end
        end
    endtask

    initial begin
        logic           found;
        int             g;
        logic           rst;
        logic           ordy;
        logic           xfer;
        logic [N-1:0]   e_rdy;
        logic [N*W-1:0] flat;

        vecs.push_back(mk(1, 4'hF, 32'h00, 1, 4'h0, 0, 0, 32'h00));
        vecs.push_back(mk(1, 4'hF, 32'h00, 1, 4'h0, 0, 0, 32'h00));
        vecs.push_back(mk(0, 4'hF, 32'h00, 1, 4'h1, 0, 0, 32'h00));
        vecs.push_back(mk(0, 4'hF, 32'h00, 1, 4'h2, 1, 0, 32'h00));
        vecs.push_back(mk(0, 4'hF, 32'h00, 1, 4'h4, 1, 1, 32'h01));
        vecs.push_back(mk(0, 4'hF, 32'h00, 1, 4'h8, 1, 2, 32'h02));
        vecs.push_back(mk(0, 4'hF, 32'h00, 1, 4'h1, 1, 3, 32'h03));
        vecs.push_back(mk(0, 4'hF, 32'h00, 1, 4'h2, 1, 0, 32'h00));
        vecs.push_back(mk(0, 4'h4, 32'hA9, 1, 4'h4, 1, 1, 32'h01));
        vecs.push_back(mk(0, 4'h0, 32'h00, 1, 4'h0, 1, 2, 32'hAB));
        vecs.push_back(mk(0, 4'h0, 32'h00, 1, 4'h0, 0, 2, 32'hAB));
        vecs.push_back(mk(0, 4'h0, 32'h00, 0, 4'h0, 0, 2, 32'hAB));
        vecs.push_back(mk(0, 4'h1, 32'h11, 0, 4'h1, 0, 2, 32'hAB));
        vecs.push_back(mk(0, 4'hF, 32'h20, 0, 4'h0, 1, 0, 32'h11));
        vecs.push_back(mk(0, 4'hF, 32'h20, 0, 4'h0, 1, 0, 32'h11));
        vecs.push_back(mk(0, 4'hF, 32'h20, 0, 4'h0, 1, 0, 32'h11));
        vecs.push_back(mk(0, 4'hF, 32'h20, 1, 4'h2, 1, 0, 32'h11));
        vecs.push_back(mk(0, 4'h4, 32'h30, 1, 4'h4, 1, 1, 32'h21));
        vecs.push_back(mk(0, 4'h5, 32'h40, 1, 4'h1, 1, 2, 32'h32));
        vecs.push_back(mk(0, 4'h5, 32'h40, 1, 4'h4, 1, 0, 32'h40));
        vecs.push_back(mk(0, 4'h5, 32'h40, 1, 4'h1, 1, 2, 32'h42));
        vecs.push_back(mk(0, 4'hF, 32'h50, 0, 4'h0, 1, 0, 32'h40));
        vecs.push_back(mk(1, 4'hF, 32'h50, 0, 4'h0, 1, 0, 32'h40));
        vecs.push_back(mk(0, 4'h0, 32'h00, 1, 4'h0, 0, 0, 32'h00));
        vecs.push_back(mk(0, 4'hF, 32'h60, 1, 4'h1, 0, 0, 32'h00));
        vecs.push_back(mk(0, 4'h0, 32'h00, 1, 4'h0, 1, 0, 32'h60));

        applyStimulus(1'b1, '1, '0, 1'b1);
        @(posedge clk);
        #1;

        for (int r = 0; r < vecs.size(); r++) begin
            applyStimulus(vecs[r].rst, vecs[r].val, build_msg(vecs[r].base), vecs[r].ordy);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", r), vecs[r].e_rdy, vecs[r].e_oval,
                        vecs[r].e_src, vecs[r].e_msg);
            @(posedge clk);
            #1;
        end
        $display("[TB] directed table done, checks=%0d", checks);

        applyStimulus(1'b1, '0, '0, 1'b1);
        @(posedge clk);
        #1;
        m_val = 1'b0;
        m_msg = '0;
        m_src = 0;
        m_ptr = 0;
        req_v = '0;
        for (int i = 0; i < N; i++)
            req_m[i] = '0;

        // Requesters hold valid and message until accepted, as the protocol demands.
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_v[i] && $urandom_range(0, 2) != 0) begin
                    req_v[i] = 1'b1;
                    req_m[i] = $urandom;
                end
            end
            rst  = ($urandom_range(0, 99) == 0);
            ordy = ($urandom_range(0, 3) != 0);
            flat = '0;
            for (int i = 0; i < N; i++)
                flat[i*W +: W] = req_m[i];
            applyStimulus(rst, req_v, flat, ordy);

            @(negedge clk);
            modelGrant(req_v, found, g);
            xfer  = !rst && found && (!m_val || ordy);
            e_rdy = xfer ? N'(1 << g) : '0;
            checkOutput($sformatf("rand%0d", c), e_rdy, m_val, S'(m_src), m_msg);

            if (rst) begin
                m_val = 1'b0;
                m_msg = '0;
                m_src = 0;
                m_ptr = 0;
            end else if (xfer) begin
                m_val    = 1'b1;
                m_msg    = req_m[g];
                m_src    = g;
                m_ptr    = (g + 1) % N;
                req_v[g] = 1'b0;
            end else if (m_val && ordy) begin
                m_val = 1'b0;
            end
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
